fpu32_norm_round: RTL and testbench



---
 rtl/fpu32_norm_round.sv | 180 ++++++++++++++++++
 tb/tb_fpu32_norm_round.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu32_norm_round.sv
`default_nettype none
// ============================================================================
// Module   : fpu32_norm_round
// Purpose  : Normalizes a raw FPU32 adder sum, rounds to nearest-even and packs
//            an IEEE-754 single. Optional macro FPU_DENORM_EN emits denormals
//            instead of flushing them to signed zero.
// Revision : 1.0 - initial release
// ============================================================================
module fpu32_norm_round #(
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [27:0] in_mant,
  input  logic        in_zero,
  input  logic        in_inf,
  input  logic        in_nan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_inx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

  state_t             r_state, w_state_nxt;
  logic               r_sign;
  logic signed [9:0]  r_exp, w_exp_nxt;
  logic [27:0]        r_mant, w_mant_nxt;
  logic [31:0]        r_result, w_result_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_unf, w_unf_nxt;
  logic               r_inx, w_inx_nxt;
  logic               w_sign_nxt;

  logic [2:0]         w_lz;
  logic               w_run;
  logic signed [9:0]  w_lz_s, w_lim, w_n, w_exp_shift;
  logic [27:0]        w_shifted;
  logic               w_up, w_carry, w_hid, w_inexact;
  logic [24:0]        w_sum;
  logic [22:0]        w_frac;
  logic signed [9:0]  w_rexp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_inx    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sign   <= w_sign_nxt;
      r_exp    <= w_exp_nxt;
      r_mant   <= w_mant_nxt;
      r_result <= w_result_nxt;
      r_ovf    <= w_ovf_nxt;
      r_unf    <= w_unf_nxt;
      r_inx    <= w_inx_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sign_nxt   = r_sign;
    w_exp_nxt    = r_exp;
    w_mant_nxt   = r_mant;
    w_result_nxt = r_result;
    w_ovf_nxt    = r_ovf;
    w_unf_nxt    = r_unf;
    w_inx_nxt    = r_inx;

    // Leading-zero count above the hidden bit, saturated at SHIFT_PER_CYCLE
    w_lz  = '0;
    w_run = 1'b1;
    for (int i = 0; i < SHIFT_PER_CYCLE; i++) begin
      if (w_run && !r_mant[26-i]) w_lz = w_lz + 3'd1;
      else                        w_run = 1'b0;
    end
    w_lz_s      = {7'd0, w_lz};
    w_lim       = (r_exp > 10'sd1) ? (r_exp - 10'sd1) : 10'sd0;
    w_n         = (w_lz_s < w_lim) ? w_lz_s : w_lim;
    w_shifted   = (r_mant << w_n) | {27'd0, r_mant[0]};
    w_exp_shift = r_exp - w_n;

    w_inexact = r_mant[2] | r_mant[1] | r_mant[0];
    w_up      = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
    w_sum     = {1'b0, r_mant[26:3]} + {24'd0, w_up};
    w_carry   = w_sum[24];
    w_rexp    = w_carry ? (r_exp + 10'sd1) : r_exp;
    w_hid     = w_carry | w_sum[23];
    w_frac    = w_carry ? w_sum[23:1] : w_sum[22:0];

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_sign_nxt = in_sign;
          w_exp_nxt  = {2'b00, in_exp};
          w_mant_nxt = in_mant;
          w_ovf_nxt  = 1'b0;
          w_unf_nxt  = 1'b0;
          w_inx_nxt  = 1'b0;
          if (in_nan) begin
            w_result_nxt = c_QNAN;
            w_state_nxt  = S_DONE;
          end else if (in_inf) begin
            w_result_nxt = {in_sign, 8'hFF, 23'd0};
            w_state_nxt  = S_DONE;
          end else if (in_zero || in_mant == 28'd0) begin
            w_result_nxt = {in_sign, 31'd0};
            w_state_nxt  = S_DONE;
          end else if (in_mant[27]) begin
            w_mant_nxt  = {1'b0, in_mant[27:2], in_mant[1] | in_mant[0]};
            w_exp_nxt   = {2'b00, in_exp} + 10'sd1;
            w_state_nxt = S_ROUND;
          end else if (in_mant[26]) begin
            w_state_nxt = S_ROUND;
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        w_mant_nxt = w_shifted;
        w_exp_nxt  = w_exp_shift;
        if (w_shifted[26] || w_exp_shift <= 10'sd1) w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        w_state_nxt = S_DONE;
        w_inx_nxt   = w_inexact;
        if (w_rexp >= 10'sd255) begin
          w_result_nxt = {r_sign, 8'hFF, 23'd0};
          w_ovf_nxt    = 1'b1;
          w_inx_nxt    = 1'b1;
        end else if (w_rexp <= 10'sd1 && !w_hid) begin
`ifdef FPU_DENORM_EN
          w_result_nxt = {r_sign, 8'h00, w_frac};
          w_unf_nxt    = w_inexact;
`else
          w_result_nxt = {r_sign, 31'd0};
          w_unf_nxt    = 1'b1;
          w_inx_nxt    = 1'b1;
`endif
        end else begin
          w_result_nxt = {r_sign, w_rexp[7:0], w_frac};
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign flag_ovf  = r_ovf;
  assign flag_unf  = r_unf;
  assign flag_inx  = r_inx;

endmodule
`default_nettype wire

// File: tb/tb_fpu32_norm_round.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu32_norm_round
// Purpose  : Vector table plus scoreboard bench for fpu32_norm_round, covering
//            both FPU_DENORM_EN build variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu32_norm_round;

  typedef struct {
    string       name;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic        zero;
    logic        inf;
    logic        nan;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_zero, in_inf, in_nan;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid, out_ready, flag_ovf, flag_unf, flag_inx;
  logic [31:0] result;

  logic        s4_in_valid, s4_in_ready, s4_out_valid, s4_out_ready;
  logic [31:0] s4_result;
  logic        s4_ovf, s4_unf, s4_inx;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t sb[$];
  vec_t tbl[16];

  always #5 clk = ~clk;

  fpu32_norm_round #(.SHIFT_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inx(flag_inx)
  );

  fpu32_norm_round #(.SHIFT_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(s4_in_valid), .in_ready(s4_in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
    .out_valid(s4_out_valid), .out_ready(s4_out_ready), .result(s4_result),
    .flag_ovf(s4_ovf), .flag_unf(s4_unf), .flag_inx(s4_inx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic s, input logic [7:0] e,
                              input logic [27:0] m, input logic z, input logic i,
                              input logic na, input logic [31:0] r, input logic o,
                              input logic u, input logic x, input int lat);
    vec_t v;
    v.name = n; v.sign = s; v.exp = e; v.mant = m; v.zero = z; v.inf = i; v.nan = na;
    v.res = r; v.ovf = o; v.unf = u; v.inx = x; v.lat = lat;
    return v;
  endfunction

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release out_valid", {31'd0, out_valid}, 32'd0);
    check("release in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input vec_t v, input bit rel);
    int   cyc;
    vec_t e;
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({v.name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_sign = v.sign; in_exp = v.exp; in_mant = v.mant;
    in_zero = v.zero; in_inf = v.inf; in_nan = v.nan;
    in_valid = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (sb.size() == 0) begin
      check({v.name, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.name, " latency"}, cyc, e.lat);
      check({e.name, " result"}, result, e.res);
      check({e.name, " ovf"}, {31'd0, flag_ovf}, {31'd0, e.ovf});
      check({e.name, " unf"}, {31'd0, flag_unf}, {31'd0, e.unf});
      check({e.name, " inx"}, {31'd0, flag_inx}, {31'd0, e.inx});
    end
    if (rel) release_out();
  endtask

  initial begin
    int cyc;
    tbl[0]  = mk("normal",     0, 8'd127, 28'h4000000, 0, 0, 0, 32'h3F800000, 0, 0, 0, 2);
    tbl[1]  = mk("carry",      0, 8'd127, 28'h8000000, 0, 0, 0, 32'h40000000, 0, 0, 0, 2);
    tbl[2]  = mk("overflow",   0, 8'd254, 28'h8000000, 0, 0, 0, 32'h7F800000, 1, 0, 1, 2);
    tbl[3]  = mk("lnorm",      0, 8'd130, 28'h0800000, 0, 0, 0, 32'h3F800000, 0, 0, 0, 5);
    tbl[4]  = mk("tie_even",   0, 8'd127, 28'h4000004, 0, 0, 0, 32'h3F800000, 0, 0, 1, 2);
    tbl[5]  = mk("tie_odd",    0, 8'd127, 28'h400000C, 0, 0, 0, 32'h3F800002, 0, 0, 1, 2);
    tbl[6]  = mk("rnd_carry",  0, 8'd127, 28'h7FFFFFC, 0, 0, 0, 32'h40000000, 0, 0, 1, 2);
    tbl[7]  = mk("above_half", 0, 8'd127, 28'h4000006, 0, 0, 0, 32'h3F800001, 0, 0, 1, 2);
`ifdef FPU_DENORM_EN
    tbl[8]  = mk("denorm",     0, 8'd1,   28'h2000000, 0, 0, 0, 32'h00400000, 0, 0, 0, 3);
`else
    tbl[8]  = mk("denorm",     0, 8'd1,   28'h2000000, 0, 0, 0, 32'h00000000, 0, 1, 1, 3);
`endif
    tbl[9]  = mk("nan",        0, 8'd10,  28'h4000000, 0, 0, 1, 32'h7FC00000, 0, 0, 0, 1);
    tbl[10] = mk("nan_inf",    1, 8'd10,  28'h4000000, 1, 1, 1, 32'h7FC00000, 0, 0, 0, 1);
    tbl[11] = mk("neg_inf",    1, 8'd10,  28'h4000000, 1, 1, 0, 32'hFF800000, 0, 0, 0, 1);
    tbl[12] = mk("neg_zero",   1, 8'd10,  28'h4000000, 1, 0, 0, 32'h80000000, 0, 0, 0, 1);
    tbl[13] = mk("mant_zero",  1, 8'd50,  28'h0000000, 0, 0, 0, 32'h80000000, 0, 0, 0, 1);
    tbl[14] = mk("neg_two",    1, 8'd128, 28'h4000000, 0, 0, 0, 32'hC0000000, 0, 0, 0, 2);
    tbl[15] = mk("lnorm2",     0, 8'd127, 28'h1000000, 0, 0, 0, 32'h3E800000, 0, 0, 0, 4);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    s4_in_valid = 1'b0; s4_out_ready = 1'b0;
    in_sign = 1'b0; in_exp = '0; in_mant = '0; in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset flags", {29'd0, flag_ovf, flag_unf, flag_inx}, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 16; k++) send(tbl[k], 1'b1);

    // Backpressure: result held and no new accept while out_ready is low
    send(tbl[5], 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp out_valid", {31'd0, out_valid}, 32'd1);
      check("bp result", result, 32'h3F800002);
      check("bp in_ready", {31'd0, in_ready}, 32'd0);
    end
    release_out();

    // Reset while normalizing discards the transaction
    @(negedge clk);
    in_sign = 1'b0; in_exp = 8'd130; in_mant = 28'h0800000;
    in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("shift in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid result", result, 32'd0);
    check("rst_mid in_ready", {31'd0, in_ready}, 32'd1);
    send(tbl[0], 1'b1);

    // Four-position shifter normalizes the same operand in one SHIFT cycle
    @(negedge clk);
    in_sign = 1'b0; in_exp = 8'd130; in_mant = 28'h0800000;
    in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0;
    check("spc4 in_ready", {31'd0, s4_in_ready}, 32'd1);
    s4_in_valid = 1'b1;
    @(posedge clk);
    #1;
    s4_in_valid = 1'b0;
    cyc = 1;
    while (!s4_out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("spc4 latency", cyc, 32'd3);
    check("spc4 result", s4_result, 32'h3F800000);
    check("spc4 flags", {29'd0, s4_ovf, s4_unf, s4_inx}, 32'd0);
    @(negedge clk);
    s4_out_ready = 1'b1;
    @(posedge clk);
    #1;
    s4_out_ready = 1'b0;
    check("spc4 release", {30'd0, s4_out_valid, s4_in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
